// File: rtl/lvds_rx_pkg.sv
// Shared types and sizing helpers for the LVDS receive
// word aligner and link sequencer.
package lvds_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAIL
  } chan_state_e;

  function automatic int slip_limit(
    input int df,
    input int rounds
  );
    return df * rounds;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lvds_rx_align_chan.sv
// One channel word aligner: compares the parallel word
// against the training pattern and bit-slips until it matches.
module lvds_rx_align_chan
  import lvds_rx_pkg::*;
#(
  parameter int                      DESER_FACTOR  = 6,
  parameter logic [DESER_FACTOR-1:0] TRAIN_PATTERN = 6'b111000,
  parameter int                      MATCH_COUNT   = 4,
  parameter int                      SETTLE_CYCLES = 4,
  parameter int                      SLIP_ROUNDS   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DESER_FACTOR-1:0] word_i,
  input  logic                    restart_i,
  input  logic                    abort_i,
  output logic                    bitslip_o,
  output logic                    aligned_o,
  output logic                    error_o
);

  localparam int SLIP_LIM = slip_limit(DESER_FACTOR, SLIP_ROUNDS);
  localparam int MW = cnt_w(MATCH_COUNT);
  localparam int SW = cnt_w(SLIP_LIM);
  localparam int TW = cnt_w(SETTLE_CYCLES);

  localparam logic [MW-1:0] MATCH_MAX   = MW'(MATCH_COUNT);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
  localparam logic [SW-1:0] SLIP_MAX    = SW'(SLIP_LIM);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

  chan_state_e   state_q, state_d;
  logic [MW-1:0] match_q, match_d;
  logic [SW-1:0] slip_q, slip_d;
  logic [TW-1:0] settle_q, settle_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      match_q  <= '0;
      slip_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      slip_q   <= slip_d;
      settle_q <= settle_d;
    end
  end

  // Lock loss overrides a restart issued in the same cycle.
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    slip_d   = slip_q;
    settle_d = settle_q;
    if (abort_i) begin
      state_d  = ST_IDLE;
      match_d  = '0;
      slip_d   = '0;
      settle_d = '0;
    end else if (restart_i) begin
      state_d  = ST_CHECK;
      match_d  = '0;
      slip_d   = '0;
      settle_d = '0;
    end else begin
      unique case (state_q)
        ST_CHECK: begin
          if (word_i == TRAIN_PATTERN) begin
            if (match_q != MATCH_MAX) match_d = match_q + 1'b1;
            if (match_q == MATCH_LAST) state_d = ST_LOCKED;
          end else begin
            match_d = '0;
            state_d = (slip_q == SLIP_MAX) ? ST_FAIL : ST_SLIP;
          end
        end
        ST_SLIP: begin
          if (slip_q != SLIP_MAX) slip_d = slip_q + 1'b1;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
          else settle_d = settle_q + 1'b1;
        end
        ST_IDLE, ST_LOCKED, ST_FAIL: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bitslip_o = (state_q == ST_SLIP);
  assign aligned_o = (state_q == ST_LOCKED);
  assign error_o   = (state_q == ST_FAIL);

endmodule

// File: rtl/lvds_rx_link_align.sv
// LVDS receive link sequencer: PLL lock sync, deserializer
// reset hold, lock-loss tracking and per-channel aligners.
module lvds_rx_link_align
  import lvds_rx_pkg::*;
#(
  parameter int                      NUM_CH        = 4,
  parameter int                      DESER_FACTOR  = 6,
  parameter logic [DESER_FACTOR-1:0] TRAIN_PATTERN = 6'b111000,
  parameter int                      MATCH_COUNT   = 4,
  parameter int                      SETTLE_CYCLES = 4,
  parameter int                      SLIP_ROUNDS   = 2,
  parameter int                      RST_HOLD      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pll_locked,
  input  logic                           align_start,
  input  logic [NUM_CH*DESER_FACTOR-1:0] rx_data,
  output logic                           rx_reset,
  output logic [NUM_CH-1:0]              bitslip,
  output logic [NUM_CH-1:0]              ch_aligned,
  output logic [NUM_CH-1:0]              ch_error,
  output logic                           all_aligned,
  output logic                           lock_lost
);

  localparam int HW = cnt_w(RST_HOLD);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD);

  logic [1:0]    sync_q;
  logic          locked_s;
  logic          locked_prev_q;
  logic [HW-1:0] hold_q, hold_d;
  logic          lock_lost_q, lock_lost_d;
  logic          all_aligned_q;
  logic          accept;
  logic          abort;
  logic          lock_fall;

  assign locked_s  = sync_q[1];
  assign rx_reset  = ~locked_s | (hold_q != HOLD_MAX);
  assign accept    = align_start & ~rx_reset;
  assign abort     = ~locked_s;
  assign lock_fall = locked_prev_q & ~locked_s;

  always_comb begin
    hold_d = hold_q;
    if (!locked_s) hold_d = '0;
    else if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
  end

  // Fall and accept are exclusive: accept needs locked_s high.
  always_comb begin
    lock_lost_d = lock_lost_q;
    unique case (1'b1)
      lock_fall: lock_lost_d = 1'b1;
      accept:    lock_lost_d = 1'b0;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      locked_prev_q <= 1'b0;
      hold_q        <= '0;
      lock_lost_q   <= 1'b0;
      all_aligned_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], pll_locked};
      locked_prev_q <= locked_s;
      hold_q        <= hold_d;
      lock_lost_q   <= lock_lost_d;
      all_aligned_q <= &ch_aligned;
    end
  end

  assign lock_lost   = lock_lost_q;
  assign all_aligned = all_aligned_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    lvds_rx_align_chan #(
      .DESER_FACTOR (DESER_FACTOR),
      .TRAIN_PATTERN(TRAIN_PATTERN),
      .MATCH_COUNT  (MATCH_COUNT),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .SLIP_ROUNDS  (SLIP_ROUNDS)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .word_i   (rx_data[i*DESER_FACTOR +: DESER_FACTOR]),
      .restart_i(accept),
      .abort_i  (abort),
      .bitslip_o(bitslip[i]),
      .aligned_o(ch_aligned[i]),
      .error_o  (ch_error[i])
    );
  end

endmodule

// File: tb/tb_lvds_rx_link_align.sv
// Bench for lvds_rx_link_align: rotating-word deserializer
// model with timing predicted from the alignment rules.
module tb_lvds_rx_link_align;

  localparam int NC = 4;
  localparam int DF = 6;
  localparam logic [DF-1:0] TP = 6'b111000;
  localparam int MC = 4;
  localparam int SC = 4;
  localparam int SR = 2;
  localparam int RH = 16;
  localparam int LIMIT = DF * SR;
  localparam int PER = 2 + SC;
  localparam int RUN_CYC = 2 + LIMIT * PER + 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pll_locked;
  logic            align_start;
  logic [NC*DF-1:0] rx_data;
  logic            rx_reset;
  logic [NC-1:0]   bitslip;
  logic [NC-1:0]   ch_aligned;
  logic [NC-1:0]   ch_error;
  logic            all_aligned;
  logic            lock_lost;

  int n_cmp = 0;
  int n_err = 0;

  int          rot[NC];
  int          off_m[NC];
  bit          bad_m[NC];
  logic [DF-1:0] badw[NC];

  always #5 clk = ~clk;

  lvds_rx_link_align #(
    .NUM_CH(NC), .DESER_FACTOR(DF), .TRAIN_PATTERN(TP),
    .MATCH_COUNT(MC), .SETTLE_CYCLES(SC),
    .SLIP_ROUNDS(SR), .RST_HOLD(RH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .align_start(align_start),
    .rx_data    (rx_data),
    .rx_reset   (rx_reset),
    .bitslip    (bitslip),
    .ch_aligned (ch_aligned),
    .ch_error   (ch_error),
    .all_aligned(all_aligned),
    .lock_lost  (lock_lost)
  );

  function automatic logic [DF-1:0] rotl(input logic [DF-1:0] w, input int n);
    logic [DF-1:0] r;
    r = w;
    for (int k = 0; k < n; k++) r = {r[DF-2:0], r[DF-1]};
    return r;
  endfunction

  function automatic bit is_rot(input logic [DF-1:0] w);
    for (int k = 0; k < DF; k++) if (rotl(TP, k) == w) return 1'b1;
    return 1'b0;
  endfunction

  task automatic pick_bad(input int i);
    logic [DF-1:0] w;
    do w = DF'($urandom_range(0, (1 << DF) - 1)); while (is_rot(w));
    badw[i] = w;
  endtask

  // Channel word: training pattern rotated by the slips still owed.
  task automatic update_rx();
    for (int i = 0; i < NC; i++)
      rx_data[i*DF +: DF] = bad_m[i] ? badw[i] : rotl(TP, rot[i]);
  endtask

  task automatic set_all_bad();
    for (int i = 0; i < NC; i++) begin
      bad_m[i] = 1'b1;
      pick_bad(i);
    end
    update_rx();
  endtask

  task automatic run_align(input string tag);
    int ns[NC];
    int al[NC];
    int er[NC];
    int allc, es, ea, ee, emax;
    bit all_good;
    allc = -1;
    emax = 0;
    all_good = 1'b1;
    for (int i = 0; i < NC; i++) begin
      ns[i] = 0; al[i] = -1; er[i] = -1; rot[i] = off_m[i];
    end
    @(negedge clk);
    update_rx();
    align_start = 1'b1;
    @(posedge clk);
    #1 align_start = 1'b0;
    for (int c = 1; c <= RUN_CYC; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if (lock_lost !== 1'b0) begin
          n_err++;
          $display("FAIL %s lock_lost_clear got %b exp 0", tag, lock_lost);
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (bitslip[i] === 1'b1) begin
          n_cmp++;
          if (c != 2 + ns[i] * PER) begin
            n_err++;
            $display("FAIL %s slip_cycle ch%0d got %0d exp %0d",
                     tag, i, c, 2 + ns[i] * PER);
          end
          ns[i]++;
          rot[i] = (rot[i] + DF - 1) % DF;
        end
        if (ch_aligned[i] === 1'b1 && al[i] < 0) al[i] = c;
        if (ch_error[i] === 1'b1 && er[i] < 0) er[i] = c;
      end
      if (c >= 2 && all_aligned === 1'b1 && allc < 0) allc = c;
      update_rx();
    end
    for (int i = 0; i < NC; i++) begin
      if (bad_m[i]) begin
        es = LIMIT; ea = -1; ee = 2 + LIMIT * PER; all_good = 1'b0;
      end else begin
        es = off_m[i]; ea = 1 + off_m[i] * PER + MC; ee = -1;
        if (ea > emax) emax = ea;
      end
      n_cmp++;
      if (ns[i] != es) begin
        n_err++;
        $display("FAIL %s slip_count ch%0d got %0d exp %0d", tag, i, ns[i], es);
      end
      n_cmp++;
      if (al[i] != ea) begin
        n_err++;
        $display("FAIL %s aligned_cycle ch%0d got %0d exp %0d", tag, i, al[i], ea);
      end
      n_cmp++;
      if (er[i] != ee) begin
        n_err++;
        $display("FAIL %s error_cycle ch%0d got %0d exp %0d", tag, i, er[i], ee);
      end
    end
    n_cmp++;
    if (allc != (all_good ? emax + 1 : -1)) begin
      n_err++;
      $display("FAIL %s all_aligned_cycle got %0d exp %0d",
               tag, allc, all_good ? emax + 1 : -1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pll_locked = 1'b0;
    align_start = 1'b0;
    set_all_bad();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rx_reset, bitslip, ch_aligned, ch_error, all_aligned, lock_lost}
        !== {1'b1, {(3*NC+2){1'b0}}}) begin
      n_err++;
      $display("FAIL reset_values got %b exp %b",
               {rx_reset, bitslip, ch_aligned, ch_error, all_aligned, lock_lost},
               {1'b1, {(3*NC+2){1'b0}}});
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (rx_reset !== 1'b1 || lock_lost !== 1'b0) begin
      n_err++;
      $display("FAIL unlocked_hold got rx_reset=%b lock_lost=%b exp 1 0",
               rx_reset, lock_lost);
    end
  endtask

  // Common to lock rise and post-reset: count edges to rx_reset drop.
  task automatic test_lock_rise(input string tag, input bit poke);
    int drop;
    int slips;
    drop = -1;
    slips = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      align_start = poke && (k == 10);
      if (rx_reset === 1'b0 && drop < 0) drop = k;
      if (k > 10 && k <= 2 + RH && (bitslip !== '0 || ch_error !== '0)) slips++;
    end
    align_start = 1'b0;
    n_cmp++;
    if (drop != 2 + RH) begin
      n_err++;
      $display("FAIL %s rx_reset_drop got %0d exp %0d", tag, drop, 2 + RH);
    end
    n_cmp++;
    if (slips != 0) begin
      n_err++;
      $display("FAIL %s fsm_idle got %0d active cycles exp 0", tag, slips);
    end
    n_cmp++;
    if (lock_lost !== 1'b0) begin
      n_err++;
      $display("FAIL %s lock_lost_after_rise got %b exp 0", tag, lock_lost);
    end
  endtask

  task automatic test_pll_lock();
    set_all_bad();
    @(negedge clk);
    pll_locked = 1'b1;
    test_lock_rise("pll_lock", 1'b1);
  endtask

  task automatic test_basic();
    off_m[0] = 0; bad_m[0] = 1'b0;
    off_m[1] = 3; bad_m[1] = 1'b0;
    off_m[2] = 0; bad_m[2] = 1'b1; pick_bad(2);
    off_m[3] = $urandom_range(0, DF - 1); bad_m[3] = 1'b0;
    run_align("basic");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < NC; i++) begin
        off_m[i] = $urandom_range(0, DF - 1);
        bad_m[i] = (it > 0) && ($urandom_range(0, 5) == 0);
        if (bad_m[i]) pick_bad(i);
      end
      run_align("random");
    end
  endtask

  task automatic test_lock_loss();
    int act;
    act = 0;
    off_m[0] = 0;
    for (int i = 0; i < NC; i++) begin
      bad_m[i] = 1'b0;
      if (i > 0) off_m[i] = 2;
      rot[i] = off_m[i];
    end
    @(negedge clk);
    update_rx();
    align_start = 1'b1;
    @(posedge clk);
    #1 align_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 8) pll_locked = 1'b0;
      if (c == 9) begin
        n_cmp++;
        if (rx_reset !== 1'b0) begin
          n_err++;
          $display("FAIL loss_sync_delay got rx_reset=%b exp 0", rx_reset);
        end
      end
      if (c == 10) begin
        n_cmp++;
        if (ch_aligned[0] !== 1'b1 || rx_reset !== 1'b1 || lock_lost !== 1'b0) begin
          n_err++;
          $display("FAIL loss_pre got al0=%b rx_reset=%b lock_lost=%b exp 1 1 0",
                   ch_aligned[0], rx_reset, lock_lost);
        end
        align_start = 1'b1;
      end
      if (c == 11) begin
        align_start = 1'b0;
        n_cmp++;
        if (ch_aligned !== '0 || ch_error !== '0 || lock_lost !== 1'b1 ||
            rx_reset !== 1'b1) begin
          n_err++;
          $display("FAIL loss_post got al=%b er=%b lock_lost=%b rx_reset=%b exp 0 0 1 1",
                   ch_aligned, ch_error, lock_lost, rx_reset);
        end
      end
      if (c >= 11 && bitslip !== '0) act++;
    end
    n_cmp++;
    if (act != 0) begin
      n_err++;
      $display("FAIL loss_idle got %0d slip cycles exp 0", act);
    end
    pll_locked = 1'b1;
    repeat (2 + RH + 2) @(negedge clk);
    n_cmp++;
    if (rx_reset !== 1'b0 || lock_lost !== 1'b1) begin
      n_err++;
      $display("FAIL loss_sticky got rx_reset=%b lock_lost=%b exp 0 1",
               rx_reset, lock_lost);
    end
    for (int i = 0; i < NC; i++) off_m[i] = $urandom_range(0, DF - 1);
    run_align("relock");
  endtask

  task automatic test_async_reset();
    off_m[0] = 0;
    for (int i = 0; i < NC; i++) begin
      bad_m[i] = 1'b0;
      if (i > 0) off_m[i] = 2;
      rot[i] = off_m[i];
    end
    @(negedge clk);
    update_rx();
    align_start = 1'b1;
    @(posedge clk);
    #1 align_start = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (bitslip[1] !== 1'b1 || ch_aligned[0] !== 1'b1) begin
      n_err++;
      $display("FAIL areset_pre got slip1=%b al0=%b exp 1 1", bitslip[1], ch_aligned[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rx_reset, bitslip, ch_aligned, ch_error, all_aligned, lock_lost}
        !== {1'b1, {(3*NC+2){1'b0}}}) begin
      n_err++;
      $display("FAIL areset_values got %b exp %b",
               {rx_reset, bitslip, ch_aligned, ch_error, all_aligned, lock_lost},
               {1'b1, {(3*NC+2){1'b0}}});
    end
    set_all_bad();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_lock_rise("areset", 1'b0);
    for (int i = 0; i < NC; i++) begin
      bad_m[i] = 1'b0;
      off_m[i] = $urandom_range(0, DF - 1);
    end
    run_align("resume");
  endtask

  initial begin
    rx_data = '0;
    for (int i = 0; i < NC; i++) begin
      rot[i] = 0; off_m[i] = 0; bad_m[i] = 1'b0; badw[i] = '0;
    end
    test_reset();
    test_pll_lock();
    test_basic();
    test_random();
    test_lock_loss();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lvds_rx_link_align.md
Name: lvds_rx_link_align

Overview:
- Per-channel word aligner and link sequencer for the LVDS receive path.
- Sits on the PLL's slow (frame-rate) output clock, after the hard deserializers.
- Holds the deserializers in reset until the PLL is stably locked, then bit-slips each channel until its parallel word matches a training pattern.
- Generalises the fixed 6x single-link setup to NUM_CH channels with any deserialization factor. Adds lock-loss recovery and per-channel failure reporting.

Parameters:
- NUM_CH, 4, number of LVDS receive channels.
- DESER_FACTOR, 6, bits per parallel word per channel.
- TRAIN_PATTERN, 6'b111000, expected training word; width DESER_FACTOR.
- MATCH_COUNT, 4, consecutive matching words required to declare a channel aligned.
- SETTLE_CYCLES, 4, wait cycles after a bitslip pulse before comparing again.
- SLIP_ROUNDS, 2, full rotations allowed; the slip limit is DESER_FACTOR*SLIP_ROUNDS.
- RST_HOLD, 16, cycles rx_reset stays high after the synchronised PLL lock rises.

Ports:
- clk, in, 1: frame-rate clock from the PLL.
- rst_n, in, 1: asynchronous active-low reset.
- pll_locked, in, 1: PLL lock, asynchronous to clk.
- align_start, in, 1: single-cycle request to (re)start alignment of all channels.
- rx_data, in, NUM_CH*DESER_FACTOR: parallel words; channel i occupies [i*DESER_FACTOR +: DESER_FACTOR].
- rx_reset, out, 1: deserializer reset, active-high.
- bitslip, out, NUM_CH: one-cycle slip pulses, one bit per channel.
- ch_aligned, out, NUM_CH: per-channel aligned flag.
- ch_error, out, NUM_CH: per-channel failure flag (slip limit exceeded).
- all_aligned, out, 1: AND of ch_aligned, registered.
- lock_lost, out, 1: sticky flag, set when the PLL drops lock after having been locked.

Behaviour:
- Reset (rst_n low): rx_reset=1; bitslip, ch_aligned, ch_error, all_aligned, lock_lost=0; all channel FSMs in IDLE; all counters 0.
- pll_locked passes through a 2-flop synchroniser; the synchronised signal is locked_s.
- rx_reset:
  - high while locked_s=0;
  - after locked_s rises, stays high for exactly RST_HOLD further cycles, then drops;
  - the hold counter is cleared whenever locked_s=0.
- Lock loss (locked_s 1->0):
  - next cycle all FSMs go to IDLE and ch_aligned/ch_error clear;
  - lock_lost=1 and stays set until an accepted align_start.
- align_start is accepted only when rx_reset=0. It is ignored otherwise, with no queuing.
- Accepted align_start: lock_lost clears; every channel goes to CHECK; match_cnt=0, slip_cnt=0, ch_aligned=0, ch_error=0.
- Accepted align_start from any state (including LOCKED and FAIL) restarts the channel.
- Lock loss and align_start in the same cycle: lock loss wins.
- Per-channel FSM states:
  - IDLE: wait for align_start.
  - CHECK, word equals TRAIN_PATTERN: match_cnt++. When match_cnt reaches MATCH_COUNT, go to LOCKED.
  - CHECK, mismatch: match_cnt=0. If slip_cnt == DESER_FACTOR*SLIP_ROUNDS, go to FAIL; otherwise go to SLIP.
  - SLIP: bitslip[i]=1 for exactly this cycle; slip_cnt++; go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles with no compare, then go to CHECK.
  - LOCKED: ch_aligned[i]=1. Holds until align_start or lock loss; no data checking.
  - FAIL: ch_error[i]=1. Holds until align_start or lock loss.
- Timing:
  - ch_aligned rises the cycle after the MATCH_COUNT-th matching sample.
  - all_aligned lags ch_aligned by 1 cycle.
- Counter widths:
  - match_cnt: clog2(MATCH_COUNT+1);
  - slip_cnt: clog2(DESER_FACTOR*SLIP_ROUNDS+1);
  - settle and hold counters sized from their parameters.
  - No counter wraps; each saturates at its terminal value.
- Channels are fully independent; bitslip pulses on different channels may coincide.

Decomposition:
- Shared package lvds_rx_pkg holds:
  - the FSM state enum (IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL);
  - the slip-limit and counter-width localparam functions.
- Sub-module lvds_rx_align_chan contains one channel FSM. It takes a word, restart, and abort inputs and produces bitslip, aligned, and error outputs. The top generates NUM_CH copies of it plus the synchroniser, rx_reset hold counter, and lock_lost logic.

Test Plan:
- Setup for all timed scenarios: defaults; the bench deserializer model rotates the word by one bit per slip within the SETTLE window.
- Channel 0 offset 0: align_start at cycle 0 -> no bitslip; ch_aligned[0]=1 at cycle 5.
- Channel 1 offset 3: -> exactly 3 bitslip[1] pulses at cycles 2, 8, 14; ch_aligned[1]=1 at cycle 23. General form: aligned at cycle 5+6k for offset k.
- Channel 2 never matches: -> 12 slips; ch_error[2]=1 at cycle 74; ch_aligned[2]=0; all_aligned stays 0.
- pll_locked rises: -> rx_reset drops exactly 2+RST_HOLD=18 cycles later. An align_start pulsed while rx_reset=1 is ignored: FSMs stay IDLE.
- Lock loss while channels are in SETTLE, with align_start in the same cycle: -> all FSMs IDLE, ch_aligned=0, lock_lost=1, rx_reset=1. A later accepted align_start clears lock_lost.
- rst_n asserted mid-alignment: -> all outputs at reset values immediately (async); operation resumes from IDLE after release.
